// File: rtl/aer_spike_tx.sv
// aer_spike_tx: round-robin drain of C spike FIFOs onto a 4-phase REQ/ACK AER bus.
// Optional ACK timeout is compiled in when AER_TX_TIMEOUT_EN is defined.
module aer_spike_tx #(
  parameter int M           = 8,
  parameter int C           = 2,
  parameter int CFG_W       = 2,
  parameter int CW          = (C > 1) ? $clog2(C) : 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  enable_i,
  input  logic                  lif_busy_i,
  input  logic [CFG_W-1:0]      cfg_i,
  input  logic [C-1:0]          fifo_empty_i,
  output logic [C-1:0]          fifo_r_en_o,
  input  logic [C*M-1:0]        fifo_r_data_i,
  output logic [CFG_W+CW+M-1:0] AER_ADDR_o,
  output logic                  AER_REQ_o,
  input  logic                  AER_ACK_i,
  output logic                  busy_o,
  output logic [15:0]           spike_cnt_o,
  output logic                  timeout_o
);

  localparam int AW = CFG_W + CW + M;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_REQ   = 3'd3,
    S_ACKLO = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_sel;
  logic [CW-1:0]   r_last;
  logic [CW-1:0]   w_grant;
  logic            w_any;
  logic [C*M-1:0]  w_data_shift;
  logic [M-1:0]    w_rdata;
  logic [AW-1:0]   r_addr;
  logic            r_req;
  logic            r_busy;
  logic [15:0]     r_cnt;
  logic            w_to_hit;

  // Nearest non-empty channel after 'last' wins; 'last' itself has lowest priority.
  function automatic logic [CW-1:0] rr_pick(input logic [C-1:0] avail,
                                            input logic [CW-1:0] last);
    logic [CW-1:0] pick;
    logic [C-1:0]  shifted;
    int            idx;
    pick = last;
    for (int i = C; i >= 1; i--) begin
      idx     = (int'(last) + i) % C;
      shifted = avail >> idx;
      if (shifted[0]) begin
        pick = CW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign w_any        = |(~fifo_empty_i);
  assign w_grant      = rr_pick(~fifo_empty_i, r_last);
  assign w_data_shift = fifo_r_data_i >> (int'(r_sel) * M);
  assign w_rdata      = w_data_shift[M-1:0];

`ifdef AER_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  assign w_to_hit  = (r_state == S_REQ) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_o = r_timeout;

  // Counts cycles spent waiting for ACK in REQ; cleared in every other state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_to_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Sticky timeout flag; only an ACK-less expiry in REQ sets it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_timeout <= 1'b0;
    end else if (w_to_hit && !AER_ACK_i) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end
`else
  assign w_to_hit  = 1'b0;
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; enable/lif_busy gate only the IDLE exit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable_i && !lif_busy_i && w_any) begin
          w_next = S_READ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ:  w_next = S_LATCH;
      S_LATCH: w_next = S_REQ;
      S_REQ: begin
        if (AER_ACK_i || w_to_hit) begin
          w_next = S_ACKLO;
        end else begin
          w_next = S_REQ;
        end
      end
      S_ACKLO: begin
        if (!AER_ACK_i) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_ACKLO;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: grant capture, address latch, REQ and spike counting.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sel  <= '0;
      r_last <= CW'(C - 1);
      r_addr <= '0;
      r_req  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= 16'd0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_next == S_READ) begin
            r_sel <= w_grant;
          end else begin
            r_sel <= r_sel;
          end
        end
        S_LATCH: begin
          r_addr <= {cfg_i, r_sel, w_rdata};
          r_req  <= 1'b1;
          r_last <= r_sel;
        end
        S_REQ: begin
          if (AER_ACK_i) begin
            r_req <= 1'b0;
            r_cnt <= r_cnt + 16'd1;
          end else if (w_to_hit) begin
            r_req <= 1'b0;
          end else begin
            r_req <= 1'b1;
          end
        end
        default: begin
          r_req <= r_req;
        end
      endcase
    end
  end

  assign fifo_r_en_o = (r_state == S_READ) ? (C'(1) << r_sel) : '0;
  assign AER_ADDR_o  = r_addr;
  assign AER_REQ_o   = r_req;
  assign busy_o      = r_busy;
  assign spike_cnt_o = r_cnt;

endmodule
